arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits; legal values 1..32.
REQ-002 Parameter N, default 4, number of input channels; legal values 2..16.
REQ-003 Parameter SELW, default $clog2(N), width of the channel index.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous and active-high.
REQ-006 Port in_valid  input  N  per-channel request; bit i is for channel i.
REQ-007 Port in_data  input  N*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready  output  N  per-channel accept strobe; at most one bit is set.
REQ-009 Port out_valid  output  1  output register holds a beat.
REQ-010 Port out_data  output  WIDTH  registered data of the held beat.
REQ-011 Port out_sel  output  SELW  index of the channel that sourced the held beat.
REQ-012 Port out_ready  input  1  downstream accepts the beat when it is high while out_valid is high.

Function
REQ-013 Output stage is a single register, with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 can_load = !out_valid || out_ready, evaluated combinationally.
REQ-015 Grant: combinational one-hot over in_valid, chosen by the arbitration policy (REQ-026/027); it is zero when in_valid is 0.
REQ-016 Ready: in_ready = grant when can_load is high, else all zeros; no in_valid-to-in_ready dependency except through grant.
REQ-017 Input transfer on channel i = in_valid[i] && in_ready[i]; on that edge out_data<=in_data[i], out_sel<=i, out_valid<=1.
REQ-018 Output transfer = out_valid && out_ready; with no simultaneous input transfer, out_valid<=0 and out_data/out_sel hold.
REQ-019 Simultaneous output and input transfer in one cycle: the register reloads, out_valid stays 1, and the cycle adds no bubble, giving full throughput of 1 beat/cycle.
REQ-020 Latency: a beat accepted at edge k appears on out_data after edge k, i.e. 1 cycle.
REQ-021 When FULL and out_ready=0: out_valid, out_data and out_sel are held stable, and in_ready=0.
REQ-022 Channel index arithmetic is modulo N, and pointer wrap from N-1 goes to 0, including when N is not a power of two.
REQ-023 A requester may drop in_valid before it is granted; no grant is stored across cycles.

Reset
REQ-024 While reset is high: out_valid=0, out_data=0, out_sel=0, round-robin pointer=0, and in_ready=0 asynchronously.
REQ-025 Reset asserted mid-operation discards any held beat without an output transfer; the first grant after release uses pointer=0.

Configuration
REQ-026 With macro ARB_MUX_RR_EN defined, arbitration is round-robin: search starts at pointer and proceeds upward modulo N; on each input transfer from channel i, pointer<=(i+1) mod N.
REQ-027 With ARB_MUX_RR_EN undefined, arbitration is fixed priority (lowest index wins), the pointer register is not built, and all other behaviour is identical.

Structure
REQ-028 Shared package arb_mux_pkg holds localparam defaults (WIDTH_DEF=8, N_DEF=4) and the state enum {EMPTY, FULL}.
REQ-029 Sub-module arb_mux_grant (combinational priority picker: in_valid, pointer -> one-hot grant plus encoded index) is instantiated once.
REQ-030 No latches; every always block is fully assigned or clocked.

Verification
REQ-031 Reset held high with in_valid=4'b1111: in_ready=0 and out_valid=0 throughout; after release, the first beat comes from ch0.
REQ-032 RR_EN, N=4, in_valid=4'b1111 constant, out_ready=1: out_sel sequence is 0,1,2,3,0 on consecutive cycles, with no bubbles.
REQ-033 Fixed priority (macro undefined), in_valid=4'b1010, out_ready=1: ch1 is granted every cycle, and ch3 is granted only after ch1 drops valid.
REQ-034 out_ready=0 for 3 cycles with data 8'hA5 held: out_data stays 8'hA5, in_ready=0, and no beat is lost or duplicated.
REQ-035 N=3, RR_EN, ch2 transfers: the pointer wraps to 0, and the next grant with in_valid=3'b111 is ch0.
REQ-036 Reset pulsed while FULL with 8'h3C held: out_valid drops immediately (asynchronously), and 8'h3C is never transferred.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared defaults and output-stage state encoding for the arb_mux channel arbiter/multiplexer.
package arb_mux_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int N_DEF     = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/arb_mux_grant.sv
// Combinational priority picker: first requester found searching upward from ptr, modulo N.
module arb_mux_grant #(
   parameter int N    = 4,
   parameter int SELW = 2
) (
   input  logic [N-1:0]    valid,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] idx
);

   int   c;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         // explicit wrap keeps the search correct for non-power-of-two N
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         if (!found && valid[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = SELW'(c);
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage.
// Define ARB_MUX_RR_EN for round-robin arbitration; otherwise lowest index wins.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int N     = N_DEF,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   input  logic               out_ready
);

   // Handshake: a beat moves on a rising edge where valid and ready are both high;
   // in_ready never waits on anything but the grant and the output stage having room.

   state_t            state, state_nxt;
   logic              can_load;
   logic              load;
   logic [N-1:0]      grant;
   logic [SELW-1:0]   grant_idx;
   logic [SELW-1:0]   ptr;

   arb_mux_grant #(
      .N    (N),
      .SELW (SELW)
   ) u_grant (
      .valid (in_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign out_valid = (state == FULL);
   assign can_load  = !out_valid || out_ready;
   assign in_ready  = (can_load && !reset) ? grant : '0;
   assign load      = |(in_valid & in_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load)           state_nxt = FULL;
      else if (out_ready) state_nxt = EMPTY;
   end

   // out_data/out_sel only change on a load, so they hold through drains and stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data <= '0;
         out_sel  <= '0;
      end else if (load) begin
         out_data <= in_data[grant_idx*WIDTH +: WIDTH];
         out_sel  <= grant_idx;
      end
   end

`ifdef ARB_MUX_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     ptr <= '0;
      else if (load) ptr <= (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
   end
`else
   assign ptr = '0;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: N=4 and N=3 instances; expectations follow ARB_MUX_RR_EN.
module tb_arb_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  v4;
   logic [31:0] d4;
   logic [3:0]  rdy4;
   logic        ov4;
   logic [7:0]  od4;
   logic [1:0]  os4;
   logic        or4;
   logic [2:0]  v3;
   logic [23:0] d3;
   logic [2:0]  rdy3;
   logic        ov3;
   logic [7:0]  od3;
   logic [1:0]  os3;
   logic        or3;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef ARB_MUX_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clk = ~clk;

   arb_mux #(.WIDTH(8), .N(4)) u4 (
      .clk(clk), .reset(rst), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
      .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(or4)
   );

   arb_mux #(.WIDTH(8), .N(3)) u3 (
      .clk(clk), .reset(rst), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
      .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(or3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      v4  = '0;
      v3  = '0;
      or4 = 1'b0;
      or3 = 1'b0;
      d4  = {8'h13, 8'h12, 8'h11, 8'h10};
      d3  = {8'h32, 8'h31, 8'h30};
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      v4  = 4'b1111;
      v3  = '0;
      or4 = 1'b1;
      or3 = 1'b0;
      d4  = {8'h13, 8'h12, 8'h11, 8'h10};
      d3  = {8'h32, 8'h31, 8'h30};
      for (int i = 0; i < 3; i++) begin
         tick;
         n_tests++;
         if (rdy4 !== 4'b0000 || ov4 !== 1'b0 || od4 !== 8'h00 || os4 !== 2'd0) begin
            $display("FAIL reset_hold cyc%0d: in_ready=%b out_valid=%b data=%h sel=%0d, want 0000 0 00 0",
                     i, rdy4, ov4, od4, os4);
            n_fail++;
         end
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (rdy4 !== 4'b0001) begin
         $display("FAIL reset_release_ready: in_ready=%b, want 0001", rdy4);
         n_fail++;
      end
      tick;
      n_tests++;
      if (ov4 !== 1'b1 || os4 !== 2'd0 || od4 !== 8'h10) begin
         $display("FAIL reset_first_beat: valid=%b sel=%0d data=%h, want 1 0 10", ov4, os4, od4);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_sel;
      do_reset;
      v4  = 4'b1111;
      or4 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick;
         exp_sel = RR ? 2'(c % 4) : 2'd0;
         n_tests++;
         if (ov4 !== 1'b1 || os4 !== exp_sel || od4 !== (8'h10 + 8'(exp_sel))) begin
            $display("FAIL back_to_back cyc%0d: valid=%b sel=%0d data=%h, want 1 %0d %h",
                     c, ov4, os4, od4, exp_sel, 8'h10 + 8'(exp_sel));
            n_fail++;
         end
      end
   endtask

   task automatic test_priority;
      logic [1:0] exp_sel;
      do_reset;
      v4  = 4'b1010;
      or4 = 1'b1;
      #1;
      n_tests++;
      if (rdy4 !== 4'b0010) begin
         $display("FAIL prio_ready: in_ready=%b, want 0010", rdy4);
         n_fail++;
      end
      for (int c = 0; c < 3; c++) begin
         tick;
         exp_sel = (RR && (c % 2 == 1)) ? 2'd3 : 2'd1;
         n_tests++;
         if (ov4 !== 1'b1 || os4 !== exp_sel) begin
            $display("FAIL prio_1010 cyc%0d: valid=%b sel=%0d, want 1 %0d", c, ov4, os4, exp_sel);
            n_fail++;
         end
      end
      v4 = 4'b1000;
      tick;
      n_tests++;
      if (ov4 !== 1'b1 || os4 !== 2'd3 || od4 !== 8'h13) begin
         $display("FAIL prio_ch3_after_drop: valid=%b sel=%0d data=%h, want 1 3 13", ov4, os4, od4);
         n_fail++;
      end
   endtask

   task automatic test_stall;
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      do_reset;
      exp_q = {8'hA5, 8'h5A};
      d4[7:0] = 8'hA5;
      v4  = 4'b0001;
      or4 = 1'b0;
      #1;
      n_tests++;
      if (rdy4 !== 4'b0001) begin
         $display("FAIL stall_empty_ready: in_ready=%b, want 0001", rdy4);
         n_fail++;
      end
      tick;
      d4[7:0] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (ov4 !== 1'b1 || od4 !== 8'hA5 || rdy4 !== 4'b0000) begin
            $display("FAIL stall_hold cyc%0d: valid=%b data=%h in_ready=%b, want 1 a5 0000",
                     i, ov4, od4, rdy4);
            n_fail++;
         end
         tick;
      end
      or4 = 1'b1;
      #1;
      n_tests++;
      if (rdy4 !== 4'b0001) begin
         $display("FAIL stall_release_ready: in_ready=%b, want 0001", rdy4);
         n_fail++;
      end
      if (ov4 && or4) got_q.push_back(od4);
      tick;
      n_tests++;
      if (ov4 !== 1'b1 || od4 !== 8'h5A) begin
         $display("FAIL stall_reload: valid=%b data=%h, want 1 5a", ov4, od4);
         n_fail++;
      end
      v4 = 4'b0000;
      if (ov4 && or4) got_q.push_back(od4);
      tick;
      n_tests++;
      if (ov4 !== 1'b0) begin
         $display("FAIL stall_drain: valid=%b, want 0", ov4);
         n_fail++;
      end
      n_tests++;
      if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
         $display("FAIL stall_beats: got %0d beats (%h %h), want 2 (a5 5a)",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx,
                  (got_q.size() > 1) ? got_q[1] : 8'hxx);
         n_fail++;
      end
   endtask

   task automatic test_wrap;
      logic [1:0] exp_sel;
      do_reset;
      v3  = 3'b100;
      or3 = 1'b1;
      tick;
      n_tests++;
      if (ov3 !== 1'b1 || os3 !== 2'd2 || od3 !== 8'h32) begin
         $display("FAIL wrap_ch2: valid=%b sel=%0d data=%h, want 1 2 32", ov3, os3, od3);
         n_fail++;
      end
      v3 = 3'b111;
      #1;
      n_tests++;
      if (rdy3 !== 3'b001) begin
         $display("FAIL wrap_ready: in_ready=%b, want 001", rdy3);
         n_fail++;
      end
      for (int c = 0; c < 4; c++) begin
         tick;
         exp_sel = RR ? 2'(c % 3) : 2'd0;
         n_tests++;
         if (ov3 !== 1'b1 || os3 !== exp_sel) begin
            $display("FAIL wrap_seq cyc%0d: valid=%b sel=%0d, want 1 %0d", c, ov3, os3, exp_sel);
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      d4[7:0] = 8'h3C;
      v4  = 4'b0001;
      or4 = 1'b0;
      tick;
      n_tests++;
      if (ov4 !== 1'b1 || od4 !== 8'h3C) begin
         $display("FAIL midrst_load: valid=%b data=%h, want 1 3c", ov4, od4);
         n_fail++;
      end
      v4 = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (ov4 !== 1'b0 || od4 !== 8'h00 || rdy4 !== 4'b0000) begin
         $display("FAIL midrst_async: valid=%b data=%h in_ready=%b, want 0 00 0000", ov4, od4, rdy4);
         n_fail++;
      end
      or4 = 1'b1;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_tests++;
         if (ov4 !== 1'b0 || od4 === 8'h3C) begin
            $display("FAIL midrst_no_beat cyc%0d: valid=%b data=%h, want 0 and not 3c", i, ov4, od4);
            n_fail++;
         end
      end
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_priority;
      test_stall;
      test_wrap;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
